// File: rtl/data_worker_pkg.sv
// Shared definitions for the data_worker AHB-Lite burst engine.
// Bus words are 32 bits; payloads up to MAX_PAYLOAD_BITS wide.
package data_worker_pkg;

  localparam int unsigned WORD_BITS        = 32;
  localparam int unsigned MAX_PAYLOAD_BITS = 1024;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_DONE
  } state_t;

  // Payload slot that carries beat k.
  function automatic int unsigned slot_index(input int unsigned k, input int unsigned nwords,
                                             input logic reverse_word);
    return reverse_word ? (nwords - 1 - k) : k;
  endfunction

  function automatic logic [WORD_BITS-1:0] byte_swap(input logic [WORD_BITS-1:0] w);
    logic [WORD_BITS-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < WORD_BITS / 8; b++)
      r[8*b +: 8] = w[8*(WORD_BITS/8 - 1 - b) +: 8];
    return r;
  endfunction

  function automatic logic [WORD_BITS-1:0] word_select(input logic [MAX_PAYLOAD_BITS-1:0] payload,
                                                       input int unsigned k,
                                                       input int unsigned nwords,
                                                       input logic reverse_word,
                                                       input logic reverse_byte);
    logic [WORD_BITS-1:0] w;
    w = payload[slot_index(k, nwords, reverse_word)*WORD_BITS +: WORD_BITS];
    return reverse_byte ? byte_swap(w) : w;
  endfunction

endpackage

// File: rtl/data_worker_if.sv
// AHB-Lite master bus plus internal client handshake for data_worker.
interface data_worker_if #(
  parameter int unsigned pAHB_ADDR_WIDTH    = 32,
  parameter int unsigned pAHB_DATA_WIDTH    = 32,
  parameter int unsigned pAHB_BURST_WIDTH   = 3,
  parameter int unsigned pAHB_PROT_WIDTH    = 4,
  parameter int unsigned pAHB_SIZE_WIDTH    = 3,
  parameter int unsigned pAHB_TRANS_WIDTH   = 2,
  parameter int unsigned pAHB_HRESP_WIDTH   = 2,
  parameter int unsigned pPAYLOAD_SIZE_BITS = 128
);
  logic [pAHB_ADDR_WIDTH-1:0]    O_haddr;
  logic [pAHB_BURST_WIDTH-1:0]   O_hburst;
  logic                          O_hmastlock;
  logic [pAHB_PROT_WIDTH-1:0]    O_hprot;
  logic                          O_hnonsec;
  logic [pAHB_SIZE_WIDTH-1:0]    O_hsize;
  logic [pAHB_TRANS_WIDTH-1:0]   O_htrans;
  logic [pAHB_DATA_WIDTH-1:0]    O_hwdata;
  logic                          O_hwrite;
  logic [pAHB_DATA_WIDTH-1:0]    I_hrdata;
  logic                          I_hready;
  logic [pAHB_HRESP_WIDTH-1:0]   I_hresp;
  logic                          I_hreadyout;
  logic [pAHB_ADDR_WIDTH-1:0]    I_int_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_wdata;
  logic                          I_int_write;
  logic [pPAYLOAD_SIZE_BITS-1:0] O_int_rdata;
  logic                          O_int_rdata_valid;
  logic                          I_go;
  logic                          O_done;

  modport master (
    output O_haddr, O_hburst, O_hmastlock, O_hprot, O_hnonsec, O_hsize, O_htrans,
           O_hwdata, O_hwrite, O_int_rdata, O_int_rdata_valid, O_done,
    input  I_hrdata, I_hready, I_hresp, I_hreadyout, I_int_addr, I_int_wdata,
           I_int_write, I_go
  );

  modport slave (
    input  O_haddr, O_hburst, O_hmastlock, O_hprot, O_hnonsec, O_hsize, O_htrans,
           O_hwdata, O_hwrite, O_int_rdata, O_int_rdata_valid, O_done,
    output I_hrdata, I_hready, I_hresp, I_hreadyout, I_int_addr, I_int_wdata,
           I_int_write, I_go
  );
endinterface

// File: rtl/data_worker_pack.sv
// Combinational payload <-> beat word mapping for the write and read paths.
module data_worker_pack
  import data_worker_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PAYLOAD_W    = 128,
  parameter int unsigned IDX_W        = 2,
  parameter bit          REVERSE_WORD = 1'b1,
  parameter bit          REVERSE_BYTE = 1'b0
) (
  input  logic [PAYLOAD_W-1:0] wpayload,
  input  logic [IDX_W-1:0]     widx,
  output logic [DATA_W-1:0]    wword,
  input  logic [PAYLOAD_W-1:0] rpayload,
  input  logic [IDX_W-1:0]     ridx,
  input  logic [DATA_W-1:0]    rword,
  output logic [PAYLOAD_W-1:0] rpayload_next
);
  localparam int unsigned NWORDS = PAYLOAD_W / DATA_W;

  logic [MAX_PAYLOAD_BITS-1:0] rext;

  assign wword = word_select(MAX_PAYLOAD_BITS'(wpayload), int'(widx), NWORDS,
                             REVERSE_WORD, REVERSE_BYTE);

  // Byte swap is its own inverse, so the read path reuses the write mapping.
  always_comb begin
    rext = MAX_PAYLOAD_BITS'(rpayload);
    rext[slot_index(int'(ridx), NWORDS, REVERSE_WORD)*WORD_BITS +: WORD_BITS] =
      REVERSE_BYTE ? byte_swap(rword) : rword;
    rpayload_next = rext[PAYLOAD_W-1:0];
  end
endmodule

// File: rtl/data_worker.sv
// Single-master AHB-Lite engine: one locked INCR burst moving a payload to/from the bus.
module data_worker
  import data_worker_pkg::*;
#(
  parameter int unsigned pAHB_ADDR_WIDTH          = 32,
  parameter int unsigned pAHB_DATA_WIDTH          = 32,
  parameter int unsigned pAHB_BURST_WIDTH         = 3,
  parameter int unsigned pAHB_PROT_WIDTH          = 4,
  parameter int unsigned pAHB_SIZE_WIDTH          = 3,
  parameter int unsigned pAHB_TRANS_WIDTH         = 2,
  parameter int unsigned pAHB_HRESP_WIDTH         = 2,
  parameter logic [3:0]  pAHB_HPROT_VALUE         = 4'b0011,
  parameter logic [2:0]  pAHB_HSIZE_VALUE         = 3'b010,
  parameter logic [2:0]  pAHB_HBURST_VALUE        = 3'b011,
  parameter logic        pAHB_HMASTLOCK_VALUE     = 1'b1,
  parameter logic        pAHB_HNONSEC_VALUE       = 1'b0,
  parameter int unsigned pPAYLOAD_SIZE_BITS       = 128,
  parameter int unsigned pMAX_TRANSFER_WAIT_COUNT = 16,
  parameter int unsigned pREVERSE_WORD_ORDER      = 1,
  parameter int unsigned pREVERSE_BYTE_ORDER      = 0
) (
  input logic         clk,
  input logic         rst,
  data_worker_if.master bus
);
  localparam int unsigned NBEATS = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned WAIT_W = $clog2(pMAX_TRANSFER_WAIT_COUNT + 1);
  localparam logic [BEAT_W-1:0] LAST_ADDR_BEAT = BEAT_W'((NBEATS >= 2) ? NBEATS - 2 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(pMAX_TRANSFER_WAIT_COUNT - 1);
  localparam logic [pAHB_ADDR_WIDTH-1:0] ADDR_STEP = pAHB_ADDR_WIDTH'(pAHB_DATA_WIDTH / 8);

  state_t                        state_q, state_n;
  htrans_t                       htrans_q, htrans_n;
  logic [pAHB_ADDR_WIDTH-1:0]    haddr_q, haddr_n;
  logic                          hwrite_q, hwrite_n;
  logic [pAHB_DATA_WIDTH-1:0]    hwdata_q, hwdata_n;
  logic [pPAYLOAD_SIZE_BITS-1:0] wdata_q, wdata_n;
  logic [pPAYLOAD_SIZE_BITS-1:0] rbuf_q, rbuf_n;
  logic [pPAYLOAD_SIZE_BITS-1:0] rdata_q, rdata_n;
  logic [BEAT_W-1:0]             beat_q, beat_n;
  logic [WAIT_W-1:0]             wait_q, wait_n;
  logic                          done_q, done_n;
  logic                          valid_q, valid_n;
  logic                          abort;

  logic [BEAT_W-1:0]             widx;
  logic [pAHB_DATA_WIDTH-1:0]    wword;
  logic [pPAYLOAD_SIZE_BITS-1:0] rpayload_next;

  // beat_q is the beat currently in its data phase; the next word to drive is beat_q+1.
  assign widx = (state_q == ST_ADDR) ? '0 : beat_q + 1'b1;

  data_worker_pack #(
    .DATA_W      (pAHB_DATA_WIDTH),
    .PAYLOAD_W   (pPAYLOAD_SIZE_BITS),
    .IDX_W       (BEAT_W),
    .REVERSE_WORD(pREVERSE_WORD_ORDER != 0),
    .REVERSE_BYTE(pREVERSE_BYTE_ORDER != 0)
  ) u_pack (
    .wpayload     (wdata_q),
    .widx         (widx),
    .wword        (wword),
    .rpayload     (rbuf_q),
    .ridx         (beat_q),
    .rword        (bus.I_hrdata),
    .rpayload_next(rpayload_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      htrans_q <= htrans_n;
      haddr_q  <= haddr_n;
      hwrite_q <= hwrite_n;
      hwdata_q <= hwdata_n;
      wdata_q  <= wdata_n;
      rbuf_q   <= rbuf_n;
      rdata_q  <= rdata_n;
      beat_q   <= beat_n;
      wait_q   <= wait_n;
      done_q   <= done_n;
      valid_q  <= valid_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    htrans_n = htrans_q;
    haddr_n  = haddr_q;
    hwrite_n = hwrite_q;
    hwdata_n = hwdata_q;
    wdata_n  = wdata_q;
    rbuf_n   = rbuf_q;
    rdata_n  = rdata_q;
    beat_n   = beat_q;
    wait_n   = wait_q;
    done_n   = 1'b0;
    valid_n  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_go) begin
          haddr_n  = bus.I_int_addr;
          wdata_n  = bus.I_int_wdata;
          hwrite_n = bus.I_int_write;
          htrans_n = HTRANS_NONSEQ;
          beat_n   = '0;
          wait_n   = '0;
          state_n  = ST_ADDR;
        end
      end
      ST_ADDR, ST_BURST, ST_LAST: begin
        if (!bus.I_hreadyout) begin
          if (wait_q == WAIT_LIMIT) abort = 1'b1;
          else wait_n = wait_q + 1'b1;
        end else if (state_q != ST_ADDR && bus.I_hresp[0]) begin
          abort = 1'b1;
        end else begin
          wait_n = '0;
          if (state_q == ST_ADDR) begin
            hwdata_n = wword;
            beat_n   = '0;
            if (NBEATS == 1) begin
              htrans_n = HTRANS_IDLE;
              state_n  = ST_LAST;
            end else begin
              htrans_n = HTRANS_SEQ;
              haddr_n  = haddr_q + ADDR_STEP;
              state_n  = ST_BURST;
            end
          end else if (state_q == ST_BURST) begin
            if (!hwrite_q) rbuf_n = rpayload_next;
            hwdata_n = wword;
            beat_n   = beat_q + 1'b1;
            if (beat_q == LAST_ADDR_BEAT) begin
              htrans_n = HTRANS_IDLE;
              state_n  = ST_LAST;
            end else begin
              htrans_n = HTRANS_SEQ;
              haddr_n  = haddr_q + ADDR_STEP;
            end
          end else begin
            done_n  = 1'b1;
            state_n = ST_DONE;
            if (!hwrite_q) begin
              rdata_n = rpayload_next;
              valid_n = 1'b1;
            end
          end
        end
        if (abort) begin
          htrans_n = HTRANS_IDLE;
          wait_n   = '0;
          done_n   = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.O_haddr           = haddr_q;
  assign bus.O_htrans          = pAHB_TRANS_WIDTH'(htrans_q);
  assign bus.O_hwrite          = hwrite_q;
  assign bus.O_hwdata          = hwdata_q;
  assign bus.O_int_rdata       = rdata_q;
  assign bus.O_int_rdata_valid = valid_q;
  assign bus.O_done            = done_q;
  assign bus.O_hburst          = pAHB_BURST_WIDTH'(pAHB_HBURST_VALUE);
  assign bus.O_hmastlock       = pAHB_HMASTLOCK_VALUE;
  assign bus.O_hprot           = pAHB_PROT_WIDTH'(pAHB_HPROT_VALUE);
  assign bus.O_hnonsec         = pAHB_HNONSEC_VALUE;
  assign bus.O_hsize           = pAHB_SIZE_WIDTH'(pAHB_HSIZE_VALUE);
endmodule

// File: tb/tb_data_worker.sv
// Directed bench for data_worker: write, read, wait states, timeout, error, re-go and reset.
module tb_data_worker;
  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned failures = 0;

  localparam logic [1:0]   T_IDLE   = 2'b00;
  localparam logic [1:0]   T_NONSEQ = 2'b10;
  localparam logic [1:0]   T_SEQ    = 2'b11;
  localparam logic [127:0] WDATA    = 128'h31c3001967d4acf1bcb25768708627ae;
  localparam logic [127:0] RDATA    = 128'h11111111222222223333333344444444;

  data_worker_if bus ();
  data_worker dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [1:0] trans, input logic [31:0] addr);
    chk({tag, "_htrans"}, 128'(bus.O_htrans), 128'(trans));
    chk({tag, "_haddr"}, 128'(bus.O_haddr), 128'(addr));
  endtask

  task automatic start(input logic [31:0] a, input logic [127:0] d, input logic w);
    bus.I_go        = 1'b1;
    bus.I_int_addr  = a;
    bus.I_int_wdata = d;
    bus.I_int_write = w;
    tick();
    bus.I_go = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.I_go        = 1'b0;
    bus.I_int_addr  = '0;
    bus.I_int_wdata = '0;
    bus.I_int_write = 1'b0;
    bus.I_hrdata    = '0;
    bus.I_hready    = 1'b1;
    bus.I_hreadyout = 1'b1;
    bus.I_hresp     = 2'b00;
    repeat (10) tick();

    chk("rst_haddr", 128'(bus.O_haddr), 128'h0);
    chk("rst_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    chk("rst_hwrite", 128'(bus.O_hwrite), 128'h0);
    chk("rst_hwdata", 128'(bus.O_hwdata), 128'h0);
    chk("rst_done", 128'(bus.O_done), 128'h0);
    chk("rst_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    chk("rst_rdata", bus.O_int_rdata, 128'h0);
    chk("const_hburst", 128'(bus.O_hburst), 128'h3);
    chk("const_hprot", 128'(bus.O_hprot), 128'h3);
    chk("const_hsize", 128'(bus.O_hsize), 128'h2);
    chk("const_hmastlock", 128'(bus.O_hmastlock), 128'h1);
    chk("const_hnonsec", 128'(bus.O_hnonsec), 128'h0);
    rst = 1'b0;
    tick();

    // Write, no wait states
    start(32'h08, WDATA, 1'b1);
    chk_addr("wr_t1", T_NONSEQ, 32'h08);
    chk("wr_t1_hwrite", 128'(bus.O_hwrite), 128'h1);
    tick();
    chk_addr("wr_t2", T_SEQ, 32'h0C);
    chk("wr_t2_hwdata", 128'(bus.O_hwdata), 128'h31c30019);
    tick();
    chk_addr("wr_t3", T_SEQ, 32'h10);
    chk("wr_t3_hwdata", 128'(bus.O_hwdata), 128'h67d4acf1);
    tick();
    chk_addr("wr_t4", T_SEQ, 32'h14);
    chk("wr_t4_hwdata", 128'(bus.O_hwdata), 128'hbcb25768);
    tick();
    chk("wr_t5_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    chk("wr_t5_hwdata", 128'(bus.O_hwdata), 128'h708627ae);
    chk("wr_t5_done", 128'(bus.O_done), 128'h0);
    tick();
    chk("wr_t6_done", 128'(bus.O_done), 128'h1);
    chk("wr_t6_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    tick();
    chk("wr_t7_done", 128'(bus.O_done), 128'h0);

    // Read, no wait states, with a stray go while busy
    start(32'h08, 128'h0, 1'b0);
    chk_addr("rd_t1", T_NONSEQ, 32'h08);
    chk("rd_t1_hwrite", 128'(bus.O_hwrite), 128'h0);
    tick();
    chk_addr("rd_t2", T_SEQ, 32'h0C);
    bus.I_hrdata = 32'h11111111;
    tick();
    chk_addr("rd_t3", T_SEQ, 32'h10);
    bus.I_hrdata    = 32'h22222222;
    bus.I_go        = 1'b1;
    bus.I_int_addr  = 32'h100;
    bus.I_int_write = 1'b1;
    tick();
    bus.I_go = 1'b0;
    chk_addr("rd_t4", T_SEQ, 32'h14);
    chk("rd_t4_hwrite", 128'(bus.O_hwrite), 128'h0);
    bus.I_hrdata = 32'h33333333;
    tick();
    chk("rd_t5_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    bus.I_hrdata = 32'h44444444;
    tick();
    chk("rd_t6_done", 128'(bus.O_done), 128'h1);
    chk("rd_t6_valid", 128'(bus.O_int_rdata_valid), 128'h1);
    chk("rd_t6_rdata", bus.O_int_rdata, RDATA);
    tick();
    chk("rd_t7_done", 128'(bus.O_done), 128'h0);
    chk("rd_t7_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    chk("rd_t7_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    tick();
    chk("rd_t8_htrans", 128'(bus.O_htrans), 128'(T_IDLE));

    // Write with three wait states during beat 2
    start(32'h20, WDATA, 1'b1);
    chk_addr("ws_t1", T_NONSEQ, 32'h20);
    tick();
    chk("ws_t2_hwdata", 128'(bus.O_hwdata), 128'h31c30019);
    tick();
    chk("ws_t3_hwdata", 128'(bus.O_hwdata), 128'h67d4acf1);
    tick();
    chk_addr("ws_t4", T_SEQ, 32'h2C);
    chk("ws_t4_hwdata", 128'(bus.O_hwdata), 128'hbcb25768);
    bus.I_hreadyout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_addr("ws_hold", T_SEQ, 32'h2C);
      chk("ws_hold_hwdata", 128'(bus.O_hwdata), 128'hbcb25768);
      chk("ws_hold_done", 128'(bus.O_done), 128'h0);
    end
    bus.I_hreadyout = 1'b1;
    tick();
    chk("ws_t8_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    chk("ws_t8_hwdata", 128'(bus.O_hwdata), 128'h708627ae);
    chk("ws_t8_done", 128'(bus.O_done), 128'h0);
    tick();
    chk("ws_t9_done", 128'(bus.O_done), 128'h1);
    chk("ws_t9_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    tick();
    chk("ws_t10_done", 128'(bus.O_done), 128'h0);

    // Timeout: 16 consecutive wait cycles on a read
    start(32'h40, 128'h0, 1'b0);
    chk_addr("to_t1", T_NONSEQ, 32'h40);
    tick();
    chk_addr("to_t2", T_SEQ, 32'h44);
    bus.I_hreadyout = 1'b0;
    bus.I_hrdata    = 32'hDEADBEEF;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_addr("to_hold", T_SEQ, 32'h44);
      chk("to_hold_done", 128'(bus.O_done), 128'h0);
    end
    tick();
    chk("to_abort_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    chk("to_abort_done", 128'(bus.O_done), 128'h1);
    chk("to_abort_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    chk("to_abort_rdata", bus.O_int_rdata, RDATA);
    bus.I_hreadyout = 1'b1;
    tick();
    chk("to_after_done", 128'(bus.O_done), 128'h0);

    // Error response on beat 1 of a read
    start(32'h80, 128'h0, 1'b0);
    chk_addr("er_t1", T_NONSEQ, 32'h80);
    tick();
    bus.I_hrdata = 32'hAAAAAAAA;
    tick();
    chk_addr("er_t3", T_SEQ, 32'h88);
    bus.I_hrdata = 32'hBBBBBBBB;
    bus.I_hresp  = 2'b01;
    tick();
    bus.I_hresp = 2'b00;
    chk("er_abort_htrans", 128'(bus.O_htrans), 128'(T_IDLE));
    chk("er_abort_done", 128'(bus.O_done), 128'h1);
    chk("er_abort_valid", 128'(bus.O_int_rdata_valid), 128'h0);
    chk("er_abort_rdata", bus.O_int_rdata, RDATA);
    tick();
    chk("er_after_done", 128'(bus.O_done), 128'h0);

    // Reset during BURST
    start(32'hC0, WDATA, 1'b1);
    chk_addr("rb_t1", T_NONSEQ, 32'hC0);
    tick();
    chk_addr("rb_t2", T_SEQ, 32'hC4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_addr("rb_reset", T_IDLE, 32'h0);
    chk("rb_reset_hwdata", 128'(bus.O_hwdata), 128'h0);
    chk("rb_reset_rdata", bus.O_int_rdata, 128'h0);
    for (int i = 0; i < 6; i++) begin
      chk("rb_no_done", 128'(bus.O_done), 128'h0);
      chk("rb_idle", 128'(bus.O_htrans), 128'(T_IDLE));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_worker.md
Name: data_worker

Overview:
- Single-master AHB-Lite burst engine that moves one pPAYLOAD_SIZE_BITS payload to or from a bus address.
- An internal client supplies address, data and direction, then pulses I_go.
- The block runs one locked INCR burst of pPAYLOAD_SIZE_BITS/pAHB_DATA_WIDTH beats (4 × 32 by default).
- Completion is reported with O_done; for reads, O_int_rdata and O_int_rdata_valid are also returned.

Parameters:
- pAHB_ADDR_WIDTH, 32, address width.
- pAHB_DATA_WIDTH, 32, bus data width.
- pAHB_BURST_WIDTH, 3; pAHB_PROT_WIDTH, 4; pAHB_SIZE_WIDTH, 3; pAHB_TRANS_WIDTH, 2; pAHB_HRESP_WIDTH, 2: AHB field widths.
- pAHB_HPROT_VALUE, 4'b0011, constant HPROT (privileged data access).
- pAHB_HSIZE_VALUE, 3'b010, constant HSIZE.
- pAHB_HBURST_VALUE, 3'b011, constant HBURST (INCR4).
- pAHB_HMASTLOCK_VALUE, 1, constant HMASTLOCK.
- pAHB_HNONSEC_VALUE, 0, constant HNONSEC.
- pPAYLOAD_SIZE_BITS, 128, payload width; must be a multiple of pAHB_DATA_WIDTH.
- pMAX_TRANSFER_WAIT_COUNT, 16, consecutive wait cycles allowed before abort.
- pREVERSE_WORD_ORDER, 1: when 1, beat 0 carries the most-significant word.
- pREVERSE_BYTE_ORDER, 0: when 1, byte-swap each beat on both write and read paths.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- O_haddr  out  ADDR  AHB address.
- O_hburst, O_hmastlock, O_hprot, O_hnonsec, O_hsize  out  field widths  driven from the constant parameters at all times.
- O_htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- O_hwdata  out  DATA  write data.
- O_hwrite  out  1  1 = write.
- I_hrdata  in  DATA  read data.
- I_hready  in  1  unused; present for port compatibility.
- I_hresp  in  2  bit0 = ERROR.
- I_hreadyout  in  1  slave ready; 0 = wait state.
- I_int_addr  in  ADDR  start address, sampled on go.
- I_int_wdata  in  PAYLOAD  write payload, sampled on go.
- I_int_write  in  1  1 = write, 0 = read; sampled on go.
- O_int_rdata  out  PAYLOAD  assembled read payload.
- O_int_rdata_valid  out  1  one-cycle pulse with O_done on a successful read.
- I_go  in  1  start; may be a 1-cycle pulse or held high.
- O_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: O_haddr, O_hwdata and O_int_rdata = 0; O_htrans = IDLE; O_hwrite, O_done and O_int_rdata_valid = 0; FSM = IDLE.
- Reset mid-burst aborts immediately with no O_done pulse.
- FSM states: IDLE → ADDR → BURST → LAST → DONE → IDLE.
- IDLE: on clk with I_go=1, latch addr, wdata and write, then go to ADDR. I_go is ignored in any other state.
- Beats N = pPAYLOAD_SIZE_BITS/pAHB_DATA_WIDTH. Beat k address = addr + 4k (no 1 KB wrap check).
- Beat k word: with pREVERSE_WORD_ORDER=1, word k = payload[PAYLOAD-1-32k -: 32]; otherwise payload[32k +: 32].
- Cycle timing with no wait states (T1 = first cycle after go is sampled):
  - T1: NONSEQ, O_haddr = A, O_hwrite = dir.
  - T2 to TN: SEQ, address A+4(k); data phase of beat k-1 runs in the same cycle.
  - TN+1: htrans = IDLE; data phase of the last beat.
  - TN+2: O_done = 1.
- Write data: O_hwdata presents beat k's word during beat k's data phase.
- Read capture: during beat k's data phase, with I_hreadyout=1, I_hrdata is stored into word k's slot (same ordering rule as writes).
- O_int_rdata updates by the DONE cycle and holds until the next read completes.
- Wait states: when I_hreadyout=0, all outputs and the beat counter hold, and the wait counter increments. The wait counter clears on any ready cycle.
- Timeout abort: wait count reaching pMAX_TRANSFER_WAIT_COUNT forces htrans = IDLE and goes to DONE with O_int_rdata_valid = 0.
- Error abort: I_hresp[0]=1 with I_hreadyout=1 gives the same abort.
- Completion: O_done pulses for exactly one cycle per accepted go. O_int_rdata_valid pulses in that same cycle only for reads completed without error.
- A go coincident with DONE is ignored; a new transfer may start the cycle after DONE.

Decomposition:
- Package data_worker_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HRESP codes;
  - the FSM state enum;
  - a function word_select(payload, k, reverse_word, reverse_byte).
- One sub-module, data_worker_pack, is natural: purely combinational payload↔beat word slicing and reordering, shared by the write and read paths.

Test Plan:
- Write, no waits: reset 10 cycles, then go with addr 0x08, data 0x31c3001967d4acf1bcb25768708627ae.
  - Expect NONSEQ@0x08, then SEQ 0x0C/0x10/0x14.
  - Expect O_hwdata 0x31c30019, 0x67d4acf1, 0xbcb25768, 0x708627ae on consecutive data phases.
  - Expect O_done in T6 and rdata_valid = 0.
- Read, no waits: go with addr 0x08 and I_hrdata returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 → O_int_rdata = 0x11111111222222223333333344444444, with valid and done together.
- Wait states: hold I_hreadyout=0 for 3 cycles during beat 2 → outputs frozen for those cycles, data correct, done delayed by 3 cycles.
- Timeout: hold I_hreadyout=0 for 16 cycles → htrans IDLE, O_done pulse, rdata_valid = 0.
- Error: I_hresp=01 on beat 1 of a read → abort with O_done and no valid.
- Re-go and reset: go asserted while busy is ignored; reset during BURST → htrans IDLE next cycle and no done.
